// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the fetch / load-store memory port arbiter.
// Load/store size codes, arbiter states, owners and the request legality check.
package riscv_mem_pkg;

  typedef enum logic [2:0] {
    LSEN_B  = 3'b000,
    LSEN_H  = 3'b001,
    LSEN_W  = 3'b010,
    LSEN_BU = 3'b011,
    LSEN_HU = 3'b100
  } lsen_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  // Fetches are always word reads, so they reuse the LS legality rules with LSEN_W.
  localparam logic [2:0] IF_LSEN = LSEN_W;

  // Only the low two address bits matter for alignment.
  function automatic logic lsen_legal(input logic [2:0] lsen, input logic we,
                                      input logic [1:0] addr_lo);
    logic ok;
    case (lsen)
      LSEN_B:  ok = 1'b1;
      LSEN_BU: ok = !we;
      LSEN_H:  ok = !addr_lo[0];
      LSEN_HU: ok = !we && !addr_lo[0];
      LSEN_W:  ok = (addr_lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_lsu_lane_align.sv
// Byte-lane steering between the right-aligned core data and the 32-bit memory word.
// Stores: byte enables and lane replication. Loads: lane select plus sign/zero extension.
module lsu_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  lsen,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    be         = 4'b1111;
    wdata_lane = wdata;
    if (we) begin
      case (lsen)
        LSEN_B, LSEN_BU: begin
          be         = 4'b0001 << addr_lo;
          wdata_lane = {4{wdata[7:0]}};
        end
        LSEN_H, LSEN_HU: begin
          be         = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_lane = {2{wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    case (addr_lo)
      2'd0:    rd_byte = rdata[7:0];
      2'd1:    rd_byte = rdata[15:8];
      2'd2:    rd_byte = rdata[23:16];
      default: rd_byte = rdata[31:24];
    endcase
    rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (lsen)
      LSEN_B:  rdata_ext = {{24{rd_byte[7]}}, rd_byte};
      LSEN_BU: rdata_ext = {24'd0, rd_byte};
      LSEN_H:  rdata_ext = {{16{rd_half[15]}}, rd_half};
      LSEN_HU: rdata_ext = {16'd0, rd_half};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and the load/store path, one outstanding transaction, with misalign and timeout errors.
//
//   state | meaning
//   IDLE  | no transaction; arbitrate requests not sampled during a gnt pulse
//   REQ   | mem_req held with latched address/data until mem_ready
//   RESP  | read accepted, waiting for mem_rvalid
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [2:0]        ls_lsen,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [31:0]       ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [31:0]       ls_rdata,
  output logic              ls_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int TIMER_W = $clog2(MAX_WAIT + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(MAX_WAIT - 1);

  arb_state_t state, state_next;
  owner_t     last_owner, owner;

  logic [ADDR_W-1:0]  lat_addr;
  logic [2:0]         lat_lsen;
  logic               lat_we;
  logic [31:0]        lat_wdata;
  logic [TIMER_W-1:0] timer;

  logic arb_en, pick_ls, win, win_legal;
  logic timeout, finish, abort;

  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, load_data;

  lsu_lane_align u_lane (
    .lsen       (lat_lsen),
    .we         (lat_we),
    .addr_lo    (lat_addr[1:0]),
    .wdata      (lat_wdata),
    .rdata      (mem_rdata),
    .be         (lane_be),
    .wdata_lane (lane_wdata),
    .rdata_ext  (load_data)
  );

  // A requester still sees its own gnt during the pulse cycle, so no arbitration then.
  always_comb begin
    arb_en = (state == IDLE) && !if_gnt && !ls_gnt;
    if (ls_req && if_req) pick_ls = (last_owner == OWN_IF);
    else                  pick_ls = ls_req;
    win       = arb_en && (if_req || ls_req);
    win_legal = pick_ls ? lsen_legal(ls_lsen, ls_we, ls_addr[1:0])
                        : lsen_legal(IF_LSEN, 1'b0, if_addr[1:0]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    finish     = 1'b0;
    abort      = 1'b0;
    timeout    = (timer == TIMER_LAST);
    case (state)
      IDLE: if (win && win_legal) state_next = REQ;
      REQ: begin
        if (mem_ready && (lat_we || mem_rvalid)) begin
          finish     = 1'b1;
          state_next = IDLE;
        end else if (timeout) begin
          abort      = 1'b1;
          state_next = IDLE;
        end else if (mem_ready) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          finish     = 1'b1;
          state_next = IDLE;
        end else if (timeout) begin
          abort      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_be    = 4'b0000;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == REQ) begin
      mem_req   = 1'b1;
      mem_we    = lat_we;
      mem_be    = lane_be;
      mem_addr  = {lat_addr[ADDR_W-1:2], 2'b00};
      mem_wdata = lat_we ? lane_wdata : 32'd0;
    end
  end

  // Timer sits at zero in IDLE, so entry to REQ always starts from a cleared count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                timer <= '0;
    else if (state == IDLE) timer <= '0;
    else                    timer <= timer + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= OWN_IF;
      owner      <= OWN_IF;
      lat_addr   <= '0;
      lat_lsen   <= LSEN_W;
      lat_we     <= 1'b0;
      lat_wdata  <= '0;
      if_gnt     <= 1'b0;
      if_rvalid  <= 1'b0;
      if_rdata   <= '0;
      if_err     <= 1'b0;
      ls_gnt     <= 1'b0;
      ls_rvalid  <= 1'b0;
      ls_rdata   <= '0;
      ls_err     <= 1'b0;
    end else begin
      if_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      ls_gnt    <= 1'b0;
      ls_rvalid <= 1'b0;
      ls_rdata  <= '0;
      ls_err    <= 1'b0;

      if (win) begin
        owner      <= pick_ls ? OWN_LS : OWN_IF;
        last_owner <= pick_ls ? OWN_LS : OWN_IF;
        if (pick_ls) begin
          lat_addr  <= ls_addr;
          lat_lsen  <= ls_lsen;
          lat_we    <= ls_we;
          lat_wdata <= ls_wdata;
          ls_gnt    <= 1'b1;
          ls_err    <= !win_legal;
        end else begin
          lat_addr  <= if_addr;
          lat_lsen  <= IF_LSEN;
          lat_we    <= 1'b0;
          lat_wdata <= '0;
          if_gnt    <= 1'b1;
          if_err    <= !win_legal;
        end
      end

      if (finish) begin
        if (owner == OWN_LS) begin
          ls_rvalid <= 1'b1;
          ls_rdata  <= lat_we ? 32'd0 : load_data;
        end else begin
          if_rvalid <= 1'b1;
          if_rdata  <= load_data;
        end
      end

      if (abort) begin
        if (owner == OWN_LS) begin
          ls_rvalid <= 1'b1;
          ls_err    <= 1'b1;
        end else begin
          if_rvalid <= 1'b1;
          if_err    <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (MAX_WAIT reduced to 4).
// Inputs change and outputs are sampled on the falling edge.
module tb_mem_port_arbiter;

  logic        clk, rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        ls_req, ls_we;
  logic [2:0]  ls_lsen;
  logic [31:0] ls_addr, ls_wdata;
  logic        ls_gnt, ls_rvalid, ls_err;
  logic [31:0] ls_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  mem_port_arbiter #(.ADDR_W(32), .MAX_WAIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .if_err     (if_err),
    .ls_req     (ls_req),
    .ls_we      (ls_we),
    .ls_lsen    (ls_lsen),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata),
    .ls_gnt     (ls_gnt),
    .ls_rvalid  (ls_rvalid),
    .ls_rdata   (ls_rdata),
    .ls_err     (ls_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pulses();
    return 32'({if_gnt, if_rvalid, if_err, ls_gnt, ls_rvalid, ls_err});
  endfunction

  task automatic ls_xact(input string tag, input logic we, input logic [2:0] lsen,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input logic [31:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                         input int gap);
    @(negedge clk);
    ls_req = 1'b1; ls_we = we; ls_lsen = lsen; ls_addr = addr; ls_wdata = wdata;
    mem_ready = 1'b1; mem_rvalid = (gap == 0); mem_rdata = rdata;
    @(negedge clk);
    check_eq({tag, "_gnt"},   32'(ls_gnt),  32'd1);
    check_eq({tag, "_err"},   32'(ls_err),  32'd0);
    check_eq({tag, "_req"},   32'(mem_req), 32'd1);
    check_eq({tag, "_we"},    32'(mem_we),  32'(we));
    check_eq({tag, "_addr"},  mem_addr,     {addr[31:2], 2'b00});
    check_eq({tag, "_be"},    32'(mem_be),  exp_be);
    check_eq({tag, "_wdata"}, mem_wdata,    exp_wdata);
    ls_req = 1'b0;
    if (!we && gap > 0) begin
      @(negedge clk);
      check_eq({tag, "_resp_req"}, 32'(mem_req), 32'd0);
      mem_ready = 1'b0;
      repeat (gap - 1) @(negedge clk);
      mem_rvalid = 1'b1;
    end
    @(negedge clk);
    check_eq({tag, "_rvalid"}, 32'(ls_rvalid), 32'd1);
    check_eq({tag, "_rdata"},  ls_rdata,       exp_rdata);
    check_eq({tag, "_rerr"},   32'(ls_err | if_rvalid), 32'd0);
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);
    check_eq({tag, "_pulse"}, 32'(ls_rvalid), 32'd0);
  endtask

  task automatic ls_illegal(input string tag, input logic we, input logic [2:0] lsen,
                            input logic [31:0] addr);
    logic seen;
    @(negedge clk);
    ls_req = 1'b1; ls_we = we; ls_lsen = lsen; ls_addr = addr; ls_wdata = 32'h1111_2222;
    mem_ready = 1'b1; mem_rvalid = 1'b1;
    @(negedge clk);
    check_eq({tag, "_gnt_err"}, 32'({ls_gnt, ls_err}), 32'd3);
    check_eq({tag, "_req"},     32'(mem_req), 32'd0);
    ls_req = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      seen |= mem_req | ls_gnt | ls_rvalid | ls_err;
    end
    check_eq({tag, "_quiet"}, 32'(seen), 32'd0);
    mem_ready = 1'b0; mem_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       seen, both;
    logic [3:0] seq;
    int         ng, n;

    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    ls_req = 1'b0; ls_we = 1'b0; ls_lsen = 3'b000; ls_addr = '0; ls_wdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_mem_req", 32'(mem_req), 32'd0);
    check_eq("rst_pulses",  pulses(),     32'd0);
    check_eq("rst_mem_be",  32'(mem_be),  32'd0);
    check_eq("rst_rdata",   if_rdata | ls_rdata | mem_addr | mem_wdata, 32'd0);
    rst = 1'b0;

    // tag, we, lsen, addr, wdata, rdata, be, mem_wdata, ls_rdata, resp gap
    ls_xact("lb",  1'b0, 3'b000, 32'h103, 32'h0,         32'h80FF_0000, 32'hF, 32'h0,         32'hFFFF_FF80, 0);
    ls_xact("sh",  1'b1, 3'b001, 32'h22,  32'h0000_ABCD, 32'h0,         32'hC, 32'hABCD_ABCD, 32'h0,         0);
    ls_xact("lhu", 1'b0, 3'b100, 32'h42,  32'h0,         32'h8001_7FFF, 32'hF, 32'h0,         32'h0000_8001, 2);
    ls_xact("sb",  1'b1, 3'b000, 32'h13,  32'h1234_565A, 32'h0,         32'h8, 32'h5A5A_5A5A, 32'h0,         0);
    ls_xact("lh",  1'b0, 3'b001, 32'h0,   32'h0,         32'h1234_8001, 32'hF, 32'h0,         32'hFFFF_8001, 1);
    ls_xact("lbu", 1'b0, 3'b011, 32'h101, 32'h0,         32'h0000_F000, 32'hF, 32'h0,         32'h0000_00F0, 0);
    ls_xact("sw",  1'b1, 3'b010, 32'h44,  32'hDEAD_BEEF, 32'h0,         32'hF, 32'hDEAD_BEEF, 32'h0,         0);
    ls_xact("lw",  1'b0, 3'b010, 32'h8,   32'h0,         32'hCAFE_F00D, 32'hF, 32'h0,         32'hCAFE_F00D, 1);

    ls_illegal("lw_mis",  1'b0, 3'b010, 32'h41);
    ls_illegal("lsen110", 1'b0, 3'b110, 32'h0);
    ls_illegal("shu",     1'b1, 3'b100, 32'h0);
    ls_illegal("lh_mis",  1'b0, 3'b001, 32'h3);

    // Misaligned fetch
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h202; mem_ready = 1'b1; mem_rvalid = 1'b1;
    @(negedge clk);
    check_eq("if_mis_gnt_err", 32'({if_gnt, if_err}), 32'd3);
    check_eq("if_mis_req",     32'(mem_req), 32'd0);
    if_req = 1'b0; mem_ready = 1'b0; mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);

    // Fetch timeout with memory never ready
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h200;
    @(negedge clk);
    check_eq("to_gnt",  32'({if_gnt, if_err}), 32'd2);
    check_eq("to_addr", mem_addr, 32'h200);
    if_req = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (!mem_req) break;
      n++;
      @(negedge clk);
    end
    check_eq("to_req_cycles", 32'(n), 32'd4);
    check_eq("to_rvalid_err", 32'({if_rvalid, if_err}), 32'd3);
    check_eq("to_rdata",      if_rdata, 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_rvalid = 1'b0;
    @(negedge clk);
    check_eq("to_late_ignored", pulses() | 32'(mem_req), 32'd0);

    // Round robin with both requesters held high from reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    if_addr = 32'h20; ls_addr = 32'h10; ls_lsen = 3'b010; ls_we = 1'b0;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    if_req = 1'b1; ls_req = 1'b1;
    seq = 4'd0; ng = 0; both = 1'b0;
    for (int i = 0; i < 20 && ng < 4; i++) begin
      @(negedge clk);
      if (if_gnt && ls_gnt) both = 1'b1;
      if (if_gnt || ls_gnt) begin
        seq = {seq[2:0], ls_gnt};
        ng++;
      end
      if (if_rvalid) check_eq("rr_if_rdata", if_rdata, 32'h1234_5678);
      if (ls_rvalid) check_eq("rr_ls_rdata", ls_rdata, 32'h1234_5678);
    end
    check_eq("rr_grants", 32'(ng), 32'd4);
    check_eq("rr_order",  32'(seq), 32'hA);
    check_eq("rr_both",   32'(both), 32'd0);
    if_req = 1'b0; ls_req = 1'b0;
    repeat (4) @(negedge clk);
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    @(negedge clk);

    // Reset while waiting in RESP
    if_req = 1'b1; if_addr = 32'h40; mem_ready = 1'b1; mem_rvalid = 1'b0;
    @(negedge clk);
    check_eq("rr_resp_gnt", 32'(if_gnt), 32'd1);
    if_req = 1'b0;
    @(negedge clk);
    check_eq("resp_state", 32'({mem_req, if_rvalid}), 32'd0);
    rst = 1'b1; mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h7777_7777;
    #1;
    check_eq("rst_resp_req",    32'(mem_req), 32'd0);
    check_eq("rst_resp_pulses", pulses(),     32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      seen |= if_rvalid | ls_rvalid | mem_req;
    end
    check_eq("rst_no_rvalid", 32'(seen), 32'd0);
    ls_addr = 32'h10; ls_lsen = 3'b010; ls_we = 1'b0; if_addr = 32'h20;
    mem_ready = 1'b1; mem_rvalid = 1'b1;
    if_req = 1'b1; ls_req = 1'b1;
    @(negedge clk);
    check_eq("rst_first_tie", 32'({ls_gnt, if_gnt}), 32'd2);
    if_req = 1'b0; ls_req = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
